// File: rtl/baud_cfg_ctrl.sv
// baud_cfg_ctrl: owns the baud_gen setting registers and applies host changes
// after quiescing the UART, restarting the generator and letting it settle.
module baud_cfg_ctrl #(
   parameter logic [15:0] RESET_FREQ   = 16'd576,
   parameter logic [15:0] RESET_LIMIT  = 16'd15049,
   parameter logic [7:0]  SETTLE_TICKS = 8'd16,
   parameter logic [15:0] IDLE_TIMEOUT = 16'd65535
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        cfg_req,
   input  logic [15:0] cfg_freq,
   input  logic [15:0] cfg_limit,
   output logic        cfg_ack,
   output logic        cfg_err,
   input  logic        tx_busy,
   input  logic        rx_busy,
   output logic        hold,
   input  logic        ce_16,
   output logic [15:0] baud_freq,
   output logic [15:0] baud_limit,
   output logic        gen_reset,
   output logic        baud_ready
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DRAIN,
      S_APPLY,
      S_SETTLE,
      S_DONE
   } state_t;

   state_t      state;
   logic [15:0] pend_freq;
   logic [15:0] pend_limit;
   logic [15:0] idle_cnt;
   logic [7:0]  tick_cnt;
   logic [16:0] cfg_sum;
   logic        cfg_bad;
   logic        uart_idle;
   logic        timed_out;
   logic        last_tick;

   // request validation and per-state event decode
   always_comb begin
      cfg_sum   = {1'b0, cfg_freq} + {1'b0, cfg_limit};
      cfg_bad   = (cfg_freq == 16'd0)
               || (cfg_freq > cfg_limit)
               || (cfg_sum > 17'h10000);
      uart_idle = !tx_busy && !rx_busy;
      timed_out = (IDLE_TIMEOUT != 16'd0)
               && (idle_cnt == IDLE_TIMEOUT);
      last_tick = ce_16
               && (({1'b0, tick_cnt} + 9'd1) == {1'b0, SETTLE_TICKS});
   end

   // control FSM; every output is a register written here
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= S_IDLE;
         baud_freq  <= RESET_FREQ;
         baud_limit <= RESET_LIMIT;
         pend_freq  <= 16'd0;
         pend_limit <= 16'd0;
         idle_cnt   <= 16'd0;
         tick_cnt   <= 8'd0;
         gen_reset  <= 1'b1;
         hold       <= 1'b0;
         cfg_ack    <= 1'b0;
         cfg_err    <= 1'b0;
         baud_ready <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (gen_reset) begin
                  // first cycle out of reset: release the generator
                  gen_reset  <= 1'b0;
                  baud_ready <= 1'b1;
               end else if (cfg_req) begin
                  if (cfg_bad) begin
                     state   <= S_DONE;
                     cfg_ack <= 1'b1;
                     cfg_err <= 1'b1;
                  end else begin
                     pend_freq  <= cfg_freq;
                     pend_limit <= cfg_limit;
                     hold       <= 1'b1;
                     baud_ready <= 1'b0;
                     idle_cnt   <= 16'd0;
                     state      <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               if (uart_idle) begin
                  baud_freq  <= pend_freq;
                  baud_limit <= pend_limit;
                  gen_reset  <= 1'b1;
                  state      <= S_APPLY;
               end else if (timed_out) begin
                  state      <= S_DONE;
                  cfg_ack    <= 1'b1;
                  cfg_err    <= 1'b1;
                  hold       <= 1'b0;
                  baud_ready <= 1'b1;
               end else begin
                  idle_cnt <= idle_cnt + 16'd1;
               end
            end
            S_APPLY: begin
               gen_reset <= 1'b0;
               tick_cnt  <= 8'd0;
               if (SETTLE_TICKS == 8'd0) begin
                  state      <= S_DONE;
                  cfg_ack    <= 1'b1;
                  cfg_err    <= 1'b0;
                  hold       <= 1'b0;
                  baud_ready <= 1'b1;
               end else begin
                  state <= S_SETTLE;
               end
            end
            S_SETTLE: begin
               if (last_tick) begin
                  state      <= S_DONE;
                  cfg_ack    <= 1'b1;
                  cfg_err    <= 1'b0;
                  hold       <= 1'b0;
                  baud_ready <= 1'b1;
               end else if (ce_16) begin
                  tick_cnt <= tick_cnt + 8'd1;
               end
            end
            S_DONE: begin
               if (!cfg_req) begin
                  cfg_ack <= 1'b0;
                  cfg_err <= 1'b0;
                  state   <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_baud_cfg_ctrl.sv
// tb_baud_cfg_ctrl: two instances (long settle / short timeout) share stimulus;
// per-cycle expectations come from a transaction-level outcome model.
module tb_baud_cfg_ctrl;

   localparam int W = 400;
   localparam logic [15:0] RF = 16'd576;
   localparam logic [15:0] RL = 16'd15049;
   localparam int TA = 65535;
   localparam int SA = 16;
   localparam int TB = 50;
   localparam int SB = 0;

   typedef struct {
      logic [15:0] f;
      logic [15:0] l;
      int txl;
      int rxl;
      int drop;
      int ack_a;
      int ack_b;
      bit err_a;
      bit err_b;
   } vec_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic cfg_req = 1'b0;
   logic tx_busy = 1'b0;
   logic rx_busy = 1'b0;
   logic ce_16 = 1'b0;
   logic [15:0] cfg_freq = 16'd0;
   logic [15:0] cfg_limit = 16'd0;

   logic a_ack, a_err, a_hold, a_grst, a_rdy;
   logic b_ack, b_err, b_hold, b_grst, b_rdy;
   logic [15:0] a_freq, a_limit, b_freq, b_limit;
   logic [36:0] act_a, act_b;

   int n_cmp = 0;
   int n_bad = 0;
   bit txv[W];
   bit rxv[W];
   bit cev[W];
   logic [15:0] cur_fa, cur_la, cur_fb, cur_lb;

   assign act_a = {a_ack, a_err, a_hold, a_rdy, a_grst, a_freq, a_limit};
   assign act_b = {b_ack, b_err, b_hold, b_rdy, b_grst, b_freq, b_limit};

   always #5 clock = ~clock;

   baud_cfg_ctrl #(
      .SETTLE_TICKS(8'd16),
      .IDLE_TIMEOUT(16'd65535)
   ) dut_a (
      .clock(clock), .reset(reset),
      .cfg_req(cfg_req), .cfg_freq(cfg_freq), .cfg_limit(cfg_limit),
      .cfg_ack(a_ack), .cfg_err(a_err),
      .tx_busy(tx_busy), .rx_busy(rx_busy), .hold(a_hold),
      .ce_16(ce_16), .baud_freq(a_freq), .baud_limit(a_limit),
      .gen_reset(a_grst), .baud_ready(a_rdy)
   );

   baud_cfg_ctrl #(
      .SETTLE_TICKS(8'd0),
      .IDLE_TIMEOUT(16'd50)
   ) dut_b (
      .clock(clock), .reset(reset),
      .cfg_req(cfg_req), .cfg_freq(cfg_freq), .cfg_limit(cfg_limit),
      .cfg_ack(b_ack), .cfg_err(b_err),
      .tx_busy(tx_busy), .rx_busy(rx_busy), .hold(b_hold),
      .ce_16(ce_16), .baud_freq(b_freq), .baud_limit(b_limit),
      .gen_reset(b_grst), .baud_ready(b_rdy)
   );

   function automatic logic [36:0] pk(input bit ack, err, hold, rdy, grst,
                                      input logic [15:0] f, l);
      return {ack, err, hold, rdy, grst, f, l};
   endfunction

   task automatic check(input string name, input logic [36:0] act,
                        input logic [36:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h (ack,err,hold,rdy,grst,freq,limit)",
                  name, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   // outcome of one request, edges counted from the edge that samples cfg_req
   function automatic void outcome(input int t, s, input logic [15:0] f, l,
                                   output bit valid, applied, err,
                                   output int k, ack_e);
      int sum;
      int ticks;
      sum = int'(f) + int'(l);
      valid = (f != 16'd0) && (f <= l) && (sum <= 65536);
      applied = 1'b0;
      err = 1'b1;
      k = -1;
      ack_e = 0;
      if (!valid) return;
      for (int j = 1; j < W; j++) begin
         if (!txv[j] && !rxv[j]) begin
            k = j;
            break;
         end
      end
      if (t != 0 && (k < 0 || k > t + 1)) begin
         ack_e = t + 1;
         return;
      end
      if (k < 0) begin
         ack_e = -1;
         return;
      end
      applied = 1'b1;
      err = 1'b0;
      if (s == 0) begin
         ack_e = k + 1;
         return;
      end
      ack_e = -1;
      ticks = 0;
      for (int j = k + 2; j < W; j++) begin
         if (cev[j]) begin
            ticks++;
            if (ticks == s) begin
               ack_e = j;
               break;
            end
         end
      end
   endfunction

   function automatic logic [36:0] expect_at(input int e,
                                             input bit valid, applied, err,
                                             input int k, ack_e, x,
                                             input logic [15:0] of, ol, nf, nl);
      bit ack;
      bit hold;
      bit usen;
      ack  = (e >= ack_e) && (e < x);
      hold = valid && (e < ack_e);
      usen = applied && (e >= k);
      return pk(ack, ack && err, hold, !hold, applied && (e == k),
                usen ? nf : of, usen ? nl : ol);
   endfunction

   task automatic set_busy(input int txl, rxl, pct, input bit rnd_ce);
      for (int j = 0; j < W; j++) begin
         txv[j] = (j >= 1) && (j <= txl) && ($urandom_range(1, 100) <= pct);
         rxv[j] = (j >= 1) && (j <= rxl) && ($urandom_range(1, 100) <= pct);
         cev[j] = (j % 4 == 0) || (rnd_ce && ($urandom_range(0, 2) == 0));
      end
   endtask

   task automatic run_txn(input logic [15:0] f, l, input int drop, rst_at,
                          output int oa, ob, output bit ea, eb);
      bit va, pa, ra, vb, pb, rb;
      int ka, aa, kb, ab, r, xa, xb, last;
      oa = -1;
      ob = -1;
      ea = 1'b0;
      eb = 1'b0;
      outcome(TA, SA, f, l, va, pa, ra, ka, aa);
      outcome(TB, SB, f, l, vb, pb, rb, kb, ab);
      if (aa < 0 || ab < 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL window: stimulus never completes");
         return;
      end
      r = (drop >= 1) ? drop : ((aa > ab ? aa : ab) + 1 + int'($urandom_range(0, 3)));
      xa = (aa + 1 > r) ? aa + 1 : r;
      xb = (ab + 1 > r) ? ab + 1 : r;
      last = (xa > xb) ? xa : xb;
      if (last >= W) begin
         n_cmp++;
         n_bad++;
         $display("FAIL window: completion beyond stimulus table");
         return;
      end
      cfg_freq = f;
      cfg_limit = l;
      for (int e = 0; e <= last; e++) begin
         if (e == rst_at) begin
            reset = 1'b1;
            cfg_req = 1'b0;
            @(posedge clock);
            #1;
            check("A in reset", act_a, pk(0, 0, 0, 0, 1, RF, RL));
            check("B in reset", act_b, pk(0, 0, 0, 0, 1, RF, RL));
            reset = 1'b0;
            @(posedge clock);
            #1;
            check("A restart", act_a, pk(0, 0, 0, 1, 0, RF, RL));
            check("B restart", act_b, pk(0, 0, 0, 1, 0, RF, RL));
            cur_fa = RF;
            cur_la = RL;
            cur_fb = RF;
            cur_lb = RL;
            return;
         end
         cfg_req = (e < r);
         tx_busy = txv[e];
         rx_busy = rxv[e];
         ce_16 = cev[e];
         @(posedge clock);
         #1;
         if (a_ack && oa < 0) begin
            oa = e;
            ea = a_err;
         end
         if (b_ack && ob < 0) begin
            ob = e;
            eb = b_err;
         end
         check($sformatf("A e%0d", e), act_a,
               expect_at(e, va, pa, ra, ka, aa, xa, cur_fa, cur_la, f, l));
         check($sformatf("B e%0d", e), act_b,
               expect_at(e, vb, pb, rb, kb, ab, xb, cur_fb, cur_lb, f, l));
      end
      if (pa) begin
         cur_fa = f;
         cur_la = l;
      end
      if (pb) begin
         cur_fb = f;
         cur_lb = l;
      end
      cfg_req = 1'b0;
      repeat (2) begin
         tx_busy = 1'($urandom_range(0, 1));
         rx_busy = 1'($urandom_range(0, 1));
         ce_16 = 1'($urandom_range(0, 1));
         @(posedge clock);
         #1;
         check("A idle", act_a, pk(0, 0, 0, 1, 0, cur_fa, cur_la));
         check("B idle", act_b, pk(0, 0, 0, 1, 0, cur_fb, cur_lb));
      end
   endtask

   initial begin
      vec_t vt[12];
      int oa, ob, mode, fi, li, drop;
      bit ea, eb;
      logic [15:0] f, l;

      vt[0]  = '{16'd48,    16'd15577, 0,   200, -1, 264, 51, 1'b0, 1'b1};
      vt[1]  = '{16'd48,    16'd15577, 0,   0,   -1, 64,  2,  1'b0, 1'b0};
      vt[2]  = '{16'd0,     16'd100,   0,   0,   -1, 0,   0,  1'b1, 1'b1};
      vt[3]  = '{16'd40000, 16'd40000, 0,   0,   -1, 0,   0,  1'b1, 1'b1};
      vt[4]  = '{16'd600,   16'd500,   0,   0,   -1, 0,   0,  1'b1, 1'b1};
      vt[5]  = '{16'd1000,  16'd20000, 100, 120, -1, 184, 51, 1'b0, 1'b1};
      vt[6]  = '{16'd32768, 16'd32768, 0,   0,   -1, 64,  2,  1'b0, 1'b0};
      vt[7]  = '{16'd2,     16'd65535, 0,   0,   -1, 0,   0,  1'b1, 1'b1};
      vt[8]  = '{16'd1,     16'd65535, 0,   0,   -1, 64,  2,  1'b0, 1'b0};
      vt[9]  = '{16'd300,   16'd9000,  50,  0,   -1, 116, 52, 1'b0, 1'b0};
      vt[10] = '{16'd301,   16'd9001,  0,   51,  -1, 116, 51, 1'b0, 1'b1};
      vt[11] = '{16'd48,    16'd15577, 0,   0,   3,  64,  2,  1'b0, 1'b0};

      reset = 1'b1;
      repeat (2) begin
         @(posedge clock);
         #1;
         check("A reset", act_a, pk(0, 0, 0, 0, 1, RF, RL));
         check("B reset", act_b, pk(0, 0, 0, 0, 1, RF, RL));
      end
      reset = 1'b0;
      @(posedge clock);
      #1;
      check("A release", act_a, pk(0, 0, 0, 1, 0, RF, RL));
      check("B release", act_b, pk(0, 0, 0, 1, 0, RF, RL));
      cur_fa = RF;
      cur_la = RL;
      cur_fb = RF;
      cur_lb = RL;

      for (int i = 0; i < 12; i++) begin
         set_busy(vt[i].txl, vt[i].rxl, 100, 1'b0);
         run_txn(vt[i].f, vt[i].l, vt[i].drop, -1, oa, ob, ea, eb);
         check_int($sformatf("v%0d A ack edge", i), oa, vt[i].ack_a);
         check_int($sformatf("v%0d B ack edge", i), ob, vt[i].ack_b);
         check_int($sformatf("v%0d A err", i), int'(ea), int'(vt[i].err_a));
         check_int($sformatf("v%0d B err", i), int'(eb), int'(vt[i].err_b));
         if (i == 0) begin
            check_int("B freq after timeout", int'(b_freq), 576);
            check_int("B limit after timeout", int'(b_limit), 15049);
            check_int("A freq after apply", int'(a_freq), 48);
            check_int("A limit after apply", int'(a_limit), 15577);
         end
      end

      set_busy(0, 0, 100, 1'b0);
      run_txn(16'd48, 16'd15577, -1, 20, oa, ob, ea, eb);
      check_int("reset in settle A ack", oa, -1);
      check_int("reset in settle A freq", int'(a_freq), 576);
      check_int("reset in settle A limit", int'(a_limit), 15049);
      run_txn(16'd48, 16'd15577, -1, -1, oa, ob, ea, eb);
      check_int("after reset A ack edge", oa, 64);
      check_int("after reset B ack edge", ob, 2);
      check_int("after reset A freq", int'(a_freq), 48);

      repeat (40) begin
         mode = int'($urandom_range(0, 4));
         case (mode)
            0: begin
               f = 16'($urandom);
               l = 16'($urandom);
            end
            1: begin
               li = int'($urandom_range(1, 65535));
               fi = int'($urandom_range(1, li));
               f = 16'(fi);
               l = 16'(li);
            end
            2: begin
               fi = int'($urandom_range(1, 32768));
               li = 65535 - fi + int'($urandom_range(0, 2));
               if (li > 65535) li = 65535;
               if (li < fi) li = fi;
               f = 16'(fi);
               l = 16'(li);
            end
            3: begin
               f = 16'd0;
               l = 16'($urandom);
            end
            default: begin
               fi = int'($urandom_range(1, 1000));
               li = int'($urandom_range(fi, 30000));
               f = 16'(fi);
               l = 16'(li);
            end
         endcase
         drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : -1;
         set_busy(int'($urandom_range(0, 120)), int'($urandom_range(0, 120)),
                  int'($urandom_range(20, 100)), 1'b1);
         run_txn(f, l, drop, -1, oa, ob, ea, eb);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/baud_cfg_ctrl.md
# baud_cfg_ctrl

Run-time configuration controller for the UART baud-rate generator. It owns the `baud_freq`/`baud_limit` setting registers and accepts change requests from a host over a four-phase handshake. Before applying a new setting it quiesces the UART TX/RX, then restarts the generator and waits a programmable number of `ce_16` ticks before acknowledging. It sits between the host register interface and `baud_gen`, and gates new frames in the UART TX/RX through `hold`.

## Interface
Parameters:
- RESET_FREQ, 16'd576: `baud_freq` value after reset (115200 baud at 50 MHz).
- RESET_LIMIT, 16'd15049: `baud_limit` value after reset.
- SETTLE_TICKS, 8'd16: number of `ce_16` pulses to wait after a restart before acking; 0 means no wait.
- IDLE_TIMEOUT, 16'd65535: maximum cycles spent in DRAIN before aborting; 0 disables the timeout.

Ports:
- clock  in  1  system clock; the only clock in the block.
- reset  in  1  synchronous, active-high reset.
- cfg_req  in  1  host request, level signal (four-phase handshake).
- cfg_freq  in  16  requested `baud_freq`; must be stable while `cfg_req` is high.
- cfg_limit  in  16  requested `baud_limit`; must be stable while `cfg_req` is high.
- cfg_ack  out  1  acknowledge; high from completion until `cfg_req` goes low.
- cfg_err  out  1  request rejected or aborted; valid while `cfg_ack` is high.
- tx_busy  in  1  UART TX is mid-frame.
- rx_busy  in  1  UART RX is mid-frame.
- hold  out  1  tells TX/RX not to start new frames.
- ce_16  in  1  tick from `baud_gen`.
- baud_freq  out  16  setting to `baud_gen`.
- baud_limit  out  16  setting to `baud_gen`.
- gen_reset  out  1  drives the `baud_gen` reset input.
- baud_ready  out  1  generator is running with a stable setting.

## Operation
- All outputs are registered.
- Reset values:
  - `baud_freq` = RESET_FREQ, `baud_limit` = RESET_LIMIT.
  - `gen_reset` = 1.
  - `hold`, `cfg_ack`, `cfg_err`, `baud_ready` = 0.
  - state = IDLE.
- First edge with `reset` low: `gen_reset` goes to 0 and `baud_ready` goes to 1.
- IDLE (`baud_ready` = 1): when `cfg_req` is sampled high, validate `cfg_freq`/`cfg_limit` using a 17-bit sum. A request is invalid if:
  - freq == 0, or
  - freq > limit, or
  - freq + limit > 65536.
- Invalid request: go to DONE with `cfg_err` = 1. Settings are unchanged and `baud_ready` stays 1.
- Valid request: capture both values into pending registers, set `hold` = 1 and `baud_ready` = 0, clear the timeout counter, and go to DRAIN.
- DRAIN: when `tx_busy` and `rx_busy` are both sampled low in the same cycle, go to APPLY.
  - If IDLE_TIMEOUT ≠ 0 and the counter reaches IDLE_TIMEOUT first: abort to DONE with `cfg_err` = 1, `hold` = 0, `baud_ready` = 1, settings unchanged.
  - If both conditions occur in the same cycle, the idle condition wins.
- APPLY (1 cycle): load `baud_freq`/`baud_limit` from the pending registers and set `gen_reset` = 1. Next state is SETTLE, or DONE if SETTLE_TICKS == 0.
- SETTLE: `gen_reset` = 0. Count `ce_16` pulses in an 8-bit counter. The APPLY-cycle tick is ignored. When the count reaches SETTLE_TICKS, go to DONE with `cfg_err` = 0, `hold` = 0, `baud_ready` = 1.
- DONE: `cfg_ack` = 1. When `cfg_req` is sampled low, drop `cfg_ack` and `cfg_err` and return to IDLE.
- Host rules:
  - A `cfg_req` drop before ack is ignored; the request completes normally.
  - A new request needs `cfg_req` low for at least one cycle in IDLE.
- `tx_busy`/`rx_busy` toggling during SETTLE has no effect. `hold` keeps new frames from starting.
- Reset asserted in any state restores all reset values immediately. The pending request is dropped and no ack is issued.

## Timing
- Edge E0 samples `cfg_req` in IDLE. After E0: DRAIN, `hold` = 1.
- If not busy at E1: after E1, new settings are out and `gen_reset` = 1.
- After E2: `gen_reset` = 0, state SETTLE.
- `cfg_ack` rises one cycle after the SETTLE_TICKS-th `ce_16` is sampled.
- SETTLE_TICKS = 0: `cfg_ack` rises after E2.
- Invalid request: `cfg_ack` and `cfg_err` both high after E0.
- Timeout abort: `cfg_ack` is high at E0 + IDLE_TIMEOUT + 1.
- `cfg_ack` falls one cycle after `cfg_req` is sampled low.
- `baud_freq`/`baud_limit` change only in the APPLY cycle or on reset.

## Test plan
- Reset, then release: `baud_freq` = 576, `baud_limit` = 15049; `gen_reset` 1→0 and `baud_ready` 0→1 on the first edge; all other outputs 0.
- Valid request freq = 48, limit = 15577 (9600 baud at 50 MHz), busy lines low, SETTLE_TICKS = 16: outputs update 2 cycles after the request; `gen_reset` is high for 1 cycle; `cfg_ack` rises after the 16th `ce_16`; `cfg_err` = 0; drop `cfg_req` and `cfg_ack` drops one cycle later.
- Invalid requests:
  - freq = 0 → immediate ack with error.
  - freq = 40000, limit = 40000 → ack with error (sum 80000).
  - freq = 600, limit = 500 → ack with error.
  - In all three cases settings are unchanged and `hold` never asserts.
- Drain wait: `tx_busy` high for 100 cycles after the request, `rx_busy` high until cycle 120: `hold` = 1 throughout and APPLY occurs in the cycle after 120.
- Timeout: IDLE_TIMEOUT = 50 with `rx_busy` stuck high: error ack at cycle 51, `hold` back to 0, settings still 576/15049.
- Reset pulse during SETTLE after applying 48/15577: outputs return to 576/15049, no ack, and a subsequent request is accepted normally.
